// File: rtl/tap_tms_sequencer.sv
// rtl/tap_tms_sequencer.sv - command-driven JTAG TAP TMS sequencer with shadow TAP state
//
// Purpose: accepts RESET / IDLE / SHIFT_IR / SHIFT_DR commands and walks the TAP
// along the shortest legal path by driving a registered TMS stream. A shadow copy
// of the TAP state machine is advanced on every edge and exported on state_obs.
//
// Ports:
//   GCLK_Pad    in   clock, all state changes on the rising edge
//   TRST_N_Pad  in   asynchronous active-low reset
//   cmd_valid   in   command present
//   cmd_ready   out  command can be accepted (= !busy)
//   cmd_op      in   0=RESET 1=IDLE 2=SHIFT_IR 3=SHIFT_DR
//   cmd_len     in   SHIFT: bit count (0 treated as 1); IDLE: RTI cycles
//   pause_req   in   request a pause mid-shift (only with TAP_SEQ_PAUSE_EN)
//   TMS_Pad     out  registered TMS to the TAP
//   shift_en    out  shadow state is ShDR/ShIR
//   shift_last  out  shift_en on the final bit
//   busy        out  command in progress
//   done        out  one-cycle pulse at command completion
//   state_obs   out  shadow TAP state, 4-bit TAP code
//
// Configuration: define TAP_SEQ_PAUSE_EN to add the pause_req port and the
// Shift -> Exit1 -> Pause -> Exit2 -> Shift detour.
module tap_tms_sequencer #(
  parameter int LEN_W          = 16,
  parameter int RST_TMS_CYCLES = 5
) (
  input  logic             GCLK_Pad,
  input  logic             TRST_N_Pad,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
`ifdef TAP_SEQ_PAUSE_EN
  input  logic             pause_req,
`endif
  output logic             TMS_Pad,
  output logic             shift_en,
  output logic             shift_last,
  output logic             busy,
  output logic             done,
  output logic [3:0]       state_obs
);

  typedef enum logic [3:0] {
    TLR    = 4'hF, RTI    = 4'hC,
    SEL_DR = 4'h7, CAP_DR = 4'h6, SH_DR = 4'h2, EX1_DR = 4'h1,
    PAU_DR = 4'h3, EX2_DR = 4'h0, UPD_DR = 4'h5,
    SEL_IR = 4'h4, CAP_IR = 4'hE, SH_IR = 4'hA, EX1_IR = 4'h9,
    PAU_IR = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
  } tap_state_e;

  typedef enum logic [1:0] {
    OP_RESET    = 2'd0,
    OP_IDLE     = 2'd1,
    OP_SHIFT_IR = 2'd2,
    OP_SHIFT_DR = 2'd3
  } op_e;

  localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0] CNT_RST = LEN_W'(RST_TMS_CYCLES);

  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    tap_state_e n;
    case (s)
      TLR:     n = tms ? TLR    : RTI;
      RTI:     n = tms ? SEL_DR : RTI;
      SEL_DR:  n = tms ? SEL_IR : CAP_DR;
      CAP_DR:  n = tms ? EX1_DR : SH_DR;
      SH_DR:   n = tms ? EX1_DR : SH_DR;
      EX1_DR:  n = tms ? UPD_DR : PAU_DR;
      PAU_DR:  n = tms ? EX2_DR : PAU_DR;
      EX2_DR:  n = tms ? UPD_DR : SH_DR;
      UPD_DR:  n = tms ? SEL_DR : RTI;
      SEL_IR:  n = tms ? TLR    : CAP_IR;
      CAP_IR:  n = tms ? EX1_IR : SH_IR;
      SH_IR:   n = tms ? EX1_IR : SH_IR;
      EX1_IR:  n = tms ? UPD_IR : PAU_IR;
      PAU_IR:  n = tms ? EX2_IR : PAU_IR;
      EX2_IR:  n = tms ? UPD_IR : SH_IR;
      UPD_IR:  n = tms ? SEL_DR : RTI;
      default: n = TLR;
    endcase
    return n;
  endfunction

  function automatic logic is_shift(input tap_state_e s);
    return (s == SH_DR) || (s == SH_IR);
  endfunction

  // TMS to drive while the shadow sits in state s; cnt is the number of shift
  // bits still to go (or remaining TMS=1 cycles for RESET).
  function automatic logic path_tms(input tap_state_e s, input op_e op,
                                    input logic [LEN_W-1:0] cnt,
                                    input logic pause_shift, input logic pause_hold);
    logic t;
    t = 1'b0;
    if (op == OP_RESET) begin
      t = (cnt != '0);
    end else if (op != OP_IDLE) begin
      case (s)
        RTI:            t = 1'b1;
        SEL_DR:         t = (op == OP_SHIFT_IR);
        SEL_IR:         t = (op == OP_SHIFT_DR);
        SH_DR, SH_IR:   t = (cnt <= CNT_ONE) || pause_shift;
        // Bits left over means Exit1 was a pause detour rather than the end.
        EX1_DR, EX1_IR: t = (cnt == '0);
        PAU_DR, PAU_IR: t = !pause_hold;
        // TLR (prepended step), Capture, Exit2 and Update all step with 0.
        default:        t = 1'b0;
      endcase
    end
    return t;
  endfunction

  logic pause_req_w;
`ifdef TAP_SEQ_PAUSE_EN
  assign pause_req_w = pause_req;
`else
  assign pause_req_w = 1'b0;
`endif

  tap_state_e       st_q, st_d;
  op_e              op_q, op_d;
  logic [LEN_W-1:0] cnt_q, cnt_d, cnt_dec;
  logic             tms_q, tms_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             shift_en_q, shift_en_d;
  logic             shift_last_q, shift_last_d;
  logic             pause_shift;
  logic             finish;

  always_comb begin
    st_d        = tap_next(st_q, tms_q);
    pause_shift = pause_req_w && shift_en_q && !shift_last_q;

    // Saturating down-count: RESET counts TMS=1 edges, IDLE counts RTI edges,
    // SHIFT counts edges leaving a Shift state (each one shifts a bit).
    cnt_dec = cnt_q;
    if (busy_q && (cnt_q != '0)) begin
      if ((op_q == OP_RESET) ||
          ((op_q == OP_IDLE) && (st_q == RTI)) ||
          (((op_q == OP_SHIFT_IR) || (op_q == OP_SHIFT_DR)) && is_shift(st_q))) begin
        cnt_dec = cnt_q - CNT_ONE;
      end
    end

    finish = 1'b0;
    if (busy_q && (st_d == RTI) && (cnt_dec == '0)) begin
      if ((op_q == OP_RESET) || (op_q == OP_IDLE)) finish = 1'b1;
      else finish = (st_q == UPD_DR) || (st_q == UPD_IR);
    end

    op_d   = op_q;
    cnt_d  = cnt_dec;
    busy_d = busy_q;
    done_d = 1'b0;
    tms_d  = tms_q;

    if (busy_q) begin
      if (finish) begin
        busy_d = 1'b0;
        done_d = 1'b1;
        tms_d  = 1'b0;
      end else begin
        tms_d = path_tms(st_d, op_q, cnt_dec, pause_shift, pause_req_w);
      end
    end else if (cmd_valid) begin
      op_d = op_e'(cmd_op);
      case (op_d)
        OP_RESET: cnt_d = CNT_RST;
        OP_IDLE:  cnt_d = cmd_len;
        default:  cnt_d = (cmd_len == '0) ? CNT_ONE : cmd_len;
      endcase
      if ((op_d == OP_IDLE) && (cmd_len == '0)) begin
        done_d = 1'b1;
      end else begin
        busy_d = 1'b1;
        tms_d  = path_tms(st_d, op_d, cnt_d, 1'b0, 1'b0);
      end
    end

    shift_en_d   = is_shift(st_d);
    shift_last_d = shift_en_d && (cnt_d == CNT_ONE);
  end

  always_ff @(posedge GCLK_Pad or negedge TRST_N_Pad) begin
    if (!TRST_N_Pad) begin
      st_q         <= TLR;
      op_q         <= OP_RESET;
      cnt_q        <= '0;
      tms_q        <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      shift_en_q   <= 1'b0;
      shift_last_q <= 1'b0;
    end else begin
      st_q         <= st_d;
      op_q         <= op_d;
      cnt_q        <= cnt_d;
      tms_q        <= tms_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      shift_en_q   <= shift_en_d;
      shift_last_q <= shift_last_d;
    end
  end

  assign cmd_ready  = !busy_q;
  assign TMS_Pad    = tms_q;
  assign shift_en   = shift_en_q;
  assign shift_last = shift_last_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign state_obs  = st_q;

endmodule

// File: tb/tb_tap_tms_sequencer.sv
// tb/tb_tap_tms_sequencer.sv - directed self-checking bench for tap_tms_sequencer
module tb_tap_tms_sequencer;

  logic        GCLK_Pad = 1'b0;
  logic        TRST_N_Pad;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_len;
`ifdef TAP_SEQ_PAUSE_EN
  logic        pause_req;
`endif
  logic        TMS_Pad;
  logic        shift_en;
  logic        shift_last;
  logic        busy;
  logic        done;
  logic [3:0]  state_obs;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] tms_v, done_v, se_v, sl_v, busy_v, rdy_v;
  logic [3:0]  st_a [0:31];

  tap_tms_sequencer #(.LEN_W(16), .RST_TMS_CYCLES(5)) dut (
    .GCLK_Pad   (GCLK_Pad),
    .TRST_N_Pad (TRST_N_Pad),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_len    (cmd_len),
`ifdef TAP_SEQ_PAUSE_EN
    .pause_req  (pause_req),
`endif
    .TMS_Pad    (TMS_Pad),
    .shift_en   (shift_en),
    .shift_last (shift_last),
    .busy       (busy),
    .done       (done),
    .state_obs  (state_obs)
  );

  always #5 GCLK_Pad = ~GCLK_Pad;

  task automatic tick();
    @(posedge GCLK_Pad);
    #1;
  endtask

  task automatic clear_logs();
    tms_v = '0; done_v = '0; se_v = '0; sl_v = '0; busy_v = '0; rdy_v = '0;
    for (int k = 0; k < 32; k++) st_a[k] = 4'h0;
  endtask

  task automatic log_at(input int i);
    tms_v[i]  = TMS_Pad;
    done_v[i] = done;
    se_v[i]   = shift_en;
    sl_v[i]   = shift_last;
    busy_v[i] = busy;
    rdy_v[i]  = cmd_ready;
    st_a[i]   = state_obs;
  endtask

  // Presents one command for a single accept edge and logs n cycles (index 0 = after accept).
  task automatic issue(input logic [1:0] op, input logic [15:0] len, input int n);
    clear_logs();
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len;
    for (int i = 0; i < n; i++) begin
      tick();
      if (i == 0) cmd_valid = 1'b0;
      log_at(i);
    end
  endtask

  task automatic test_reset();
    TRST_N_Pad = 1'b0;
    cmd_valid  = 1'b0;
    cmd_op     = 2'd0;
    cmd_len    = 16'd0;
`ifdef TAP_SEQ_PAUSE_EN
    pause_req  = 1'b0;
`endif
    #23;
    vectors++;
    if ({TMS_Pad, state_obs, cmd_ready, busy, done, shift_en, shift_last} !== 10'b1_1111_1_0_0_0_0) begin
      miscompares++;
      $display("FAIL reset_hold: got %b expected %b",
               {TMS_Pad, state_obs, cmd_ready, busy, done, shift_en, shift_last}, 10'b1111110000);
    end
    @(posedge GCLK_Pad);
    #1;
    TRST_N_Pad = 1'b1;
    tick();
    tick();
    vectors++;
    if (TMS_Pad !== 1'b1) begin
      miscompares++; $display("FAIL reset_tms: got %b expected 1", TMS_Pad);
    end
    vectors++;
    if (state_obs !== 4'hF) begin
      miscompares++; $display("FAIL reset_state: got %h expected f", state_obs);
    end
    vectors++;
    if ({cmd_ready, busy, done} !== 3'b100) begin
      miscompares++; $display("FAIL reset_handshake: got %b expected 100", {cmd_ready, busy, done});
    end
  endtask

  task automatic test_reset_op();
    issue(2'd0, 16'd0, 10);
    vectors++;
    if (tms_v[9:0] !== 10'h01F) begin
      miscompares++; $display("FAIL rstop_tms: got %h expected 01f", tms_v[9:0]);
    end
    vectors++;
    if (done_v[9:0] !== 10'h040) begin
      miscompares++; $display("FAIL rstop_done: got %h expected 040", done_v[9:0]);
    end
    vectors++;
    if (busy_v[9:0] !== 10'h03F) begin
      miscompares++; $display("FAIL rstop_busy: got %h expected 03f", busy_v[9:0]);
    end
    vectors++;
    if ({st_a[5], st_a[6]} !== 8'hFC) begin
      miscompares++; $display("FAIL rstop_state: got %h%h expected fc", st_a[5], st_a[6]);
    end
  endtask

  task automatic test_shift_dr();
    issue(2'd3, 16'd8, 16);
    vectors++;
    if (tms_v[15:0] !== 16'h0C01) begin
      miscompares++; $display("FAIL dr8_tms: got %h expected 0c01", tms_v[15:0]);
    end
    vectors++;
    if (done_v[15:0] !== 16'h2000) begin
      miscompares++; $display("FAIL dr8_done: got %h expected 2000", done_v[15:0]);
    end
    vectors++;
    if (se_v[15:0] !== 16'h07F8) begin
      miscompares++; $display("FAIL dr8_shift_en: got %h expected 07f8", se_v[15:0]);
    end
    vectors++;
    if (sl_v[15:0] !== 16'h0400) begin
      miscompares++; $display("FAIL dr8_shift_last: got %h expected 0400", sl_v[15:0]);
    end
    vectors++;
    if (busy_v[15:0] !== 16'h1FFF) begin
      miscompares++; $display("FAIL dr8_busy: got %h expected 1fff", busy_v[15:0]);
    end
    vectors++;
    if ({st_a[3], st_a[11], st_a[12], st_a[13]} !== 16'h215C) begin
      miscompares++;
      $display("FAIL dr8_states: got %h%h%h%h expected 215c", st_a[3], st_a[11], st_a[12], st_a[13]);
    end
  endtask

  task automatic test_shift_len0();
    issue(2'd3, 16'd0, 10);
    vectors++;
    if (tms_v[9:0] !== 10'h019) begin
      miscompares++; $display("FAIL dr0_tms: got %h expected 019", tms_v[9:0]);
    end
    vectors++;
    if (done_v[9:0] !== 10'h040) begin
      miscompares++; $display("FAIL dr0_done: got %h expected 040", done_v[9:0]);
    end
    vectors++;
    if ({se_v[9:0], sl_v[9:0]} !== {10'h008, 10'h008}) begin
      miscompares++; $display("FAIL dr0_shift: got %h/%h expected 008/008", se_v[9:0], sl_v[9:0]);
    end
  endtask

  task automatic test_idle();
    issue(2'd1, 16'd0, 3);
    vectors++;
    if ({done_v[2:0], busy_v[2:0], tms_v[2:0]} !== 9'b001_000_000) begin
      miscompares++;
      $display("FAIL idle0: got done %b busy %b tms %b expected 001 000 000", done_v[2:0], busy_v[2:0], tms_v[2:0]);
    end
    vectors++;
    if (st_a[0] !== 4'hC) begin
      miscompares++; $display("FAIL idle0_state: got %h expected c", st_a[0]);
    end
    issue(2'd1, 16'd3, 6);
    vectors++;
    if ({done_v[5:0], busy_v[5:0], tms_v[5:0]} !== {6'h08, 6'h07, 6'h00}) begin
      miscompares++;
      $display("FAIL idle3: got done %h busy %h tms %h expected 08 07 00", done_v[5:0], busy_v[5:0], tms_v[5:0]);
    end
    vectors++;
    if ({st_a[1], st_a[5]} !== 8'hCC) begin
      miscompares++; $display("FAIL idle3_state: got %h%h expected cc", st_a[1], st_a[5]);
    end
  endtask

  task automatic test_back_to_back();
    clear_logs();
    cmd_valid = 1'b1;
    cmd_op    = 2'd1;
    cmd_len   = 16'd2;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (i == 0) begin
        cmd_op  = 2'd3;
        cmd_len = 16'd2;
      end
      if (i == 3) cmd_valid = 1'b0;
      log_at(i);
    end
    vectors++;
    if (tms_v[13:0] !== 14'h0188) begin
      miscompares++; $display("FAIL b2b_tms: got %h expected 0188", tms_v[13:0]);
    end
    vectors++;
    if (done_v[13:0] !== 14'h0404) begin
      miscompares++; $display("FAIL b2b_done: got %h expected 0404", done_v[13:0]);
    end
    vectors++;
    if (busy_v[13:0] !== 14'h03FB) begin
      miscompares++; $display("FAIL b2b_busy: got %h expected 03fb", busy_v[13:0]);
    end
    vectors++;
    if (rdy_v[13:0] !== 14'h3C04) begin
      miscompares++; $display("FAIL b2b_ready: got %h expected 3c04", rdy_v[13:0]);
    end
  endtask

  task automatic test_trst_mid_shift();
    int done_seen;
    int bad_state;
    issue(2'd3, 16'd8, 7);
    vectors++;
    if (se_v[6] !== 1'b1) begin
      miscompares++; $display("FAIL trst_pre_shift_en: got %b expected 1", se_v[6]);
    end
    #2;
    TRST_N_Pad = 1'b0;
    #1;
    vectors++;
    if ({state_obs, TMS_Pad, shift_en, shift_last, busy, done, cmd_ready} !== 10'b1111_1_0_0_0_0_1) begin
      miscompares++;
      $display("FAIL trst_async: got %b expected 1111100001",
               {state_obs, TMS_Pad, shift_en, shift_last, busy, done, cmd_ready});
    end
    tick();
    tick();
    TRST_N_Pad = 1'b1;
    done_seen = 0;
    bad_state = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) done_seen++;
      if (state_obs !== 4'hF) bad_state++;
    end
    vectors++;
    if (done_seen != 0) begin
      miscompares++; $display("FAIL trst_no_done: got %0d done pulses expected 0", done_seen);
    end
    vectors++;
    if (bad_state != 0 || TMS_Pad !== 1'b1) begin
      miscompares++; $display("FAIL trst_after: got %0d non-TLR cycles tms %b expected 0 and 1", bad_state, TMS_Pad);
    end
  endtask

  task automatic test_shift_ir_from_tlr();
    issue(2'd2, 16'd1, 12);
    vectors++;
    if (tms_v[11:0] !== 12'h066) begin
      miscompares++; $display("FAIL ir1_tms: got %h expected 066", tms_v[11:0]);
    end
    vectors++;
    if (done_v[11:0] !== 12'h100) begin
      miscompares++; $display("FAIL ir1_done: got %h expected 100", done_v[11:0]);
    end
    vectors++;
    if ({se_v[11:0], sl_v[11:0]} !== {12'h020, 12'h020}) begin
      miscompares++; $display("FAIL ir1_shift: got %h/%h expected 020/020", se_v[11:0], sl_v[11:0]);
    end
    vectors++;
    if ({st_a[0], st_a[1], st_a[5], st_a[8]} !== 16'hFCAC) begin
      miscompares++;
      $display("FAIL ir1_states: got %h%h%h%h expected fcac", st_a[0], st_a[1], st_a[5], st_a[8]);
    end
  endtask

`ifdef TAP_SEQ_PAUSE_EN
  task automatic test_pause();
    logic [3:0] path [$];
    logic [3:0] exp_path [0:10];
    logic [3:0] last_st;
    int se_cnt, sl_cnt, done_cnt, path_bad;
    exp_path = '{4'hC, 4'h7, 4'h6, 4'h2, 4'h1, 4'h3, 4'h0, 4'h2, 4'h1, 4'h5, 4'hC};
    se_cnt = 0; sl_cnt = 0; done_cnt = 0; path_bad = 0;
    last_st = 4'hF;
    cmd_valid = 1'b1;
    cmd_op    = 2'd3;
    cmd_len   = 16'd8;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i == 0) cmd_valid = 1'b0;
      if (state_obs !== last_st) path.push_back(state_obs);
      last_st = state_obs;
      if (shift_en) se_cnt++;
      if (shift_last) sl_cnt++;
      if (done) done_cnt++;
      if (i == 5) pause_req = 1'b1;
      if (i == 10) pause_req = 1'b0;
    end
    if (path.size() != 11) path_bad = 1;
    else for (int k = 0; k < 11; k++) if (path[k] !== exp_path[k]) path_bad = 1;
    vectors++;
    if (path_bad != 0) begin
      miscompares++; $display("FAIL pause_path: got %0d distinct steps, expected c762130215c", path.size());
    end
    vectors++;
    if ({se_cnt, sl_cnt, done_cnt} !== {32'd8, 32'd1, 32'd1}) begin
      miscompares++;
      $display("FAIL pause_counts: got se %0d sl %0d done %0d expected 8 1 1", se_cnt, sl_cnt, done_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_reset_op();
    test_shift_dr();
    test_shift_len0();
    test_idle();
    test_back_to_back();
    test_trst_mid_shift();
    test_shift_ir_from_tlr();
`ifdef TAP_SEQ_PAUSE_EN
    test_pause();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
